// File: rtl/iir_dsp_pkg.sv
// Shared types for the IIR filter datapath: sample width, sample type and
// decimator FSM state encoding.
package iir_dsp_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [0:0] {
    DEC_IDLE,
    DEC_ACC
  } dec_state_e;

endpackage

// File: rtl/iir_decimator_if.sv
// Sample input, result handshake and overflow status bundle of iir_decimator.
// drop_cnt exists only when IIR_DECIMATOR_DROP_CNT_EN is defined.
interface iir_decimator_if
  import iir_dsp_pkg::*;
#(
  parameter int unsigned DW = SAMPLE_W
) ();

  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 sync_clr;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 ovf;
  logic                 clr_ovf;
`ifdef IIR_DECIMATOR_DROP_CNT_EN
  logic [7:0]           drop_cnt;
`endif

  modport master (
`ifdef IIR_DECIMATOR_DROP_CNT_EN
    input  drop_cnt,
`endif
    output in_data,
    output in_valid,
    output sync_clr,
    output out_ready,
    output clr_ovf,
    input  out_data,
    input  out_valid,
    input  ovf
  );

  modport slave (
`ifdef IIR_DECIMATOR_DROP_CNT_EN
    output drop_cnt,
`endif
    input  in_data,
    input  in_valid,
    input  sync_clr,
    input  out_ready,
    input  clr_ovf,
    output out_data,
    output out_valid,
    output ovf
  );

endinterface

// File: rtl/dec_out_fifo.sv
// Two-entry circular result buffer. A push into a full buffer is accepted only
// when a pop frees a slot in the same cycle; otherwise it is dropped and flagged.
module dec_out_fifo
  import iir_dsp_pkg::*;
#(
  parameter int unsigned DW = SAMPLE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 push,
  input  logic signed [DW-1:0] push_data,
  input  logic                 pop,
  output logic signed [DW-1:0] rd_data,
  output logic                 empty,
  output logic                 drop
);

  logic signed [DW-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic                 full;
  logic                 pop_ok;
  logic                 push_ok;

  always_comb begin
    empty   = (count == 2'd0);
    full    = (count == 2'd2);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    drop    = push && !push_ok && !clr;
    rd_data = mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clr) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iir_decimator.sv
// Boxcar decimator: averages DECIM samples with round-half-up and queues results
// in a 2-entry buffer. Define IIR_DECIMATOR_DROP_CNT_EN to add the drop counter.
module iir_decimator
  import iir_dsp_pkg::*;
#(
  parameter int unsigned DECIM = 4,
  parameter int unsigned DW    = SAMPLE_W
) (
  input logic            clk,
  input logic            rst,
  iir_decimator_if.slave bus
);

  localparam int unsigned LOG2_DECIM = $clog2(DECIM);
  localparam int unsigned SW         = DW + LOG2_DECIM;

  if (DECIM < 2 || DECIM > 64 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
    $error("iir_decimator: DECIM must be a power of two in 2..64");
  end

  localparam logic [LOG2_DECIM-1:0] LAST_PHASE = LOG2_DECIM'(DECIM - 1);
  localparam logic signed [SW-1:0]  ROUND_BIAS = SW'(1 << (LOG2_DECIM - 1));

  dec_state_e            state;
  logic [LOG2_DECIM-1:0] phase;
  logic signed [SW-1:0]  acc;
  logic signed [SW-1:0]  sample_ext;
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  rounded;
  logic signed [DW-1:0]  result;
  logic signed [DW-1:0]  emit_data;
  logic                  emit_valid;
  logic                  fifo_empty;
  logic                  drop;
  logic                  ovf_q;

  // Sum of DECIM full-scale samples plus the bias cannot exceed SW bits.
  always_comb begin
    sample_ext = SW'(bus.in_data);
    sum        = acc + sample_ext;
    rounded    = sum + ROUND_BIAS;
    result     = DW'(rounded >>> LOG2_DECIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DEC_IDLE;
      phase      <= '0;
      acc        <= '0;
      emit_data  <= '0;
      emit_valid <= 1'b0;
    end else if (bus.sync_clr) begin
      state      <= DEC_IDLE;
      phase      <= '0;
      acc        <= '0;
      emit_data  <= '0;
      emit_valid <= 1'b0;
    end else begin
      emit_valid <= 1'b0;
      if (bus.in_valid) begin
        case (state)
          DEC_IDLE: begin
            acc   <= sample_ext;
            phase <= LOG2_DECIM'(1);
            state <= DEC_ACC;
          end
          DEC_ACC: begin
            if (phase == LAST_PHASE) begin
              emit_data  <= result;
              emit_valid <= 1'b1;
              acc        <= '0;
              phase      <= '0;
              state      <= DEC_IDLE;
            end else begin
              acc   <= sum;
              phase <= phase + LOG2_DECIM'(1);
            end
          end
          default: state <= DEC_IDLE;
        endcase
      end
    end
  end

  dec_out_fifo #(
    .DW(DW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.sync_clr),
    .push     (emit_valid),
    .push_data(emit_data),
    .pop      (bus.out_ready),
    .rd_data  (bus.out_data),
    .empty    (fifo_empty),
    .drop     (drop)
  );

  assign bus.out_valid = !fifo_empty;

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.ovf = ovf_q;

`ifdef IIR_DECIMATOR_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'd0;
    end else if (bus.clr_ovf) begin
      drop_cnt_q <= {7'd0, drop};
    end else if (drop && drop_cnt_q != 8'hff) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_iir_decimator.sv
// Directed bench for iir_decimator against a queue-based block-average model.
module tb_iir_decimator;
  import iir_dsp_pkg::*;

  localparam int unsigned DECIM = 4;

  logic clk = 1'b0;
  logic rst;

  iir_decimator_if #(.DW(SAMPLE_W)) bus ();

  iir_decimator #(
    .DECIM(DECIM),
    .DW   (SAMPLE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: samples of the open block, the result awaiting its buffer slot,
  // and the buffer itself as a bounded queue.
  int  blk[$];
  bit  pend_v;
  int  pend_d;
  int  q[$];
  bit  m_ovf;
  int  m_cnt;
  int  got[$];

  function automatic int block_avg(input int s);
    int d = DECIM;
    int r = s + d / 2;
    if (r >= 0) return r / d;
    return -((-r + d - 1) / d);
  endfunction

  task automatic model_reset();
    blk.delete();
    q.delete();
    pend_v = 1'b0;
    pend_d = 0;
    m_ovf  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_step();
    bit pop;
    bit dropped;
    int s;
    pop     = (q.size() > 0) && bus.out_ready;
    dropped = 1'b0;
    if (bus.sync_clr) begin
      blk.delete();
      q.delete();
      pend_v = 1'b0;
      if (bus.clr_ovf) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end
      return;
    end
    if (pop) void'(q.pop_front());
    if (pend_v) begin
      if (q.size() < 2) q.push_back(pend_d);
      else dropped = 1'b1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (bus.clr_ovf) m_ovf = 1'b0;
    if (bus.clr_ovf) m_cnt = dropped ? 1 : 0;
    else if (dropped && m_cnt < 255) m_cnt++;
    pend_v = 1'b0;
    if (bus.in_valid) begin
      s = bus.in_data;
      blk.push_back(s);
      if (blk.size() == DECIM) begin
        pend_d = block_avg(blk.sum());
        pend_v = 1'b1;
        blk.delete();
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, plus a log of every accepted result.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("out_valid", bus.out_valid, q.size() > 0);
        if (q.size() > 0) check("out_data", bus.out_data, q[0]);
        check("ovf", bus.ovf, m_ovf);
`ifdef IIR_DECIMATOR_DROP_CNT_EN
        check("drop_cnt", bus.drop_cnt, m_cnt);
`endif
        if (bus.out_valid && bus.out_ready) got.push_back(int'(bus.out_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int d);
    bus.in_valid = v;
    bus.in_data  = 16'(d);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_block(input int v);
    for (int i = 0; i < DECIM; i++) drive(1'b1, v);
  endtask

  task automatic chk_got(input string name, input int idx, input int exp);
    check(name, (idx < got.size()) ? got[idx] : -999999, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.sync_clr  = 1'b0;
    bus.out_ready = 1'b1;
    bus.clr_ovf   = 1'b0;
    idle(2);
    rst = 1'b0;

    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_ovf", bus.ovf, 0);
`ifdef IIR_DECIMATOR_DROP_CNT_EN
    check("rst_drop_cnt", bus.drop_cnt, 0);
`endif

    // Basic average and two-cycle latency.
    got.delete();
    drive(1'b1, 100);
    drive(1'b1, 101);
    drive(1'b1, 102);
    drive(1'b1, 103);
    check("t1_lat1_valid", bus.out_valid, 0);
    tick();
    check("t1_lat2_valid", bus.out_valid, 1);
    check("t1_lat2_data", bus.out_data, 102);
    idle(3);
    check("t1_count", got.size(), 1);
    chk_got("t1_val", 0, 102);

    // Negative rounding and full-scale extremes.
    got.delete();
    drive(1'b1, -1);
    drive(1'b1, -2);
    drive(1'b1, -1);
    drive(1'b1, -2);
    send_block(32767);
    send_block(-32768);
    idle(4);
    check("t2_count", got.size(), 3);
    chk_got("t2_neg", 0, -1);
    chk_got("t2_max", 1, 32767);
    chk_got("t2_min", 2, -32768);

    // Gapped input: phase holds across idle cycles.
    got.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 10);
      drive(1'b0, 0);
    end
    idle(3);
    check("t3_count", got.size(), 2);
    chk_got("t3_val0", 0, 10);
    chk_got("t3_val1", 1, 10);

    // Stalled output: two results held, two dropped.
    got.delete();
    bus.out_ready = 1'b0;
    send_block(11);
    send_block(22);
    send_block(33);
    send_block(44);
    idle(3);
    check("t4_ovf", bus.ovf, 1);
`ifdef IIR_DECIMATOR_DROP_CNT_EN
    check("t4_drop_cnt", bus.drop_cnt, 2);
`endif
    check("t4_hold_valid", bus.out_valid, 1);
    check("t4_hold_data", bus.out_data, 11);
    bus.out_ready = 1'b1;
    idle(4);
    check("t4_count", got.size(), 2);
    chk_got("t4_val0", 0, 11);
    chk_got("t4_val1", 1, 22);
    check("t4_empty", bus.out_valid, 0);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("t4_ovf_clr", bus.ovf, 0);
`ifdef IIR_DECIMATOR_DROP_CNT_EN
    check("t4_cnt_clr", bus.drop_cnt, 0);
`endif

    // Full buffer with a pop in the same cycle as the push: nothing lost.
    got.delete();
    bus.out_ready = 1'b0;
    send_block(5);
    send_block(6);
    idle(2);
    send_block(7);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t5_ovf", bus.ovf, 0);
    check("t5_valid", bus.out_valid, 1);
    check("t5_head", bus.out_data, 6);
    bus.out_ready = 1'b1;
    idle(4);
    check("t5_count", got.size(), 3);
    chk_got("t5_val0", 0, 5);
    chk_got("t5_val1", 1, 6);
    chk_got("t5_val2", 2, 7);

    // Async reset mid-block discards the partial sum.
    got.delete();
    drive(1'b1, 7);
    drive(1'b1, 7);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    check("t6_rst_valid", bus.out_valid, 0);
    send_block(50);
    idle(4);
    check("t6_count", got.size(), 1);
    chk_got("t6_val", 0, 50);

    // sync_clr mid-block behaves the same and keeps ovf.
    bus.out_ready = 1'b0;
    send_block(1);
    send_block(1);
    send_block(1);
    idle(3);
    check("t7_ovf_set", bus.ovf, 1);
    bus.out_ready = 1'b1;
    idle(3);
    got.delete();
    drive(1'b1, 9);
    drive(1'b1, 9);
    bus.sync_clr = 1'b1;
    drive(1'b1, 9);
    bus.sync_clr = 1'b0;
    check("t7_ovf_kept", bus.ovf, 1);
    check("t7_clr_valid", bus.out_valid, 0);
    send_block(50);
    idle(4);
    check("t7_count", got.size(), 1);
    chk_got("t7_val", 0, 50);
    check("t7_ovf_end", bus.ovf, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iir_decimator.md
Name: iir_decimator

Overview:
- Downstream stage of the 16-bit IIR filter.
- Consumes one filtered sample per cycle when in_valid is high.
- Averages each block of DECIM consecutive samples (boxcar, rounded) and emits one 16-bit result per block.
- Results drain through a 2-entry output buffer with a valid/ready handshake. The block absorbs downstream stalls without back-pressuring the free-running filter.

Parameters:
- DECIM, 4, decimation ratio. Must be a power of two, 2..64. Elaboration error otherwise.
- LOG2_DECIM, $clog2(DECIM), derived. Not overridable.
- DW, 16, sample width (signed).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  DW  signed sample from the IIR filter.
- in_valid  in  1  sample qualifier. No ready is returned; every valid sample is consumed.
- sync_clr  in  1  synchronous restart of the block phase.
- out_data  out  DW  signed decimated sample (head of the output buffer).
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head when out_valid && out_ready.
- ovf  out  1  sticky flag: a result was dropped because the buffer was full.
- clr_ovf  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears:
  - FSM to IDLE, acc = 0, phase = 0.
  - Buffer empty: out_valid = 0, out_data = 0.
  - ovf = 0.
- FSM states:
  - IDLE: accumulator empty. An in_valid sample loads acc = sext(in_data) and sets phase = 1, then goes to ACC. If DECIM == 2 the next sample completes the block.
  - ACC: each valid sample does acc += sext(in_data) and phase++.
  - On the valid sample that makes phase == DECIM:
    - sum = acc + sext(in_data) (width DW+LOG2_DECIM).
    - result = (sum + 2^(LOG2_DECIM-1)) >>> LOG2_DECIM, which rounds half toward +inf.
    - result is registered into the EMIT stage, acc and phase are cleared, and the FSM returns to IDLE.
  - Cycles with in_valid low hold acc, phase and state.
- EMIT stage (1 register):
  - The registered result is pushed into the buffer on the following cycle.
  - Latency: out_valid rises 2 cycles after the completing sample's clock edge when the buffer is empty.
  - A new sample arriving in the same cycle as the EMIT push is accumulated normally, so back-to-back blocks are sustainable.
- Result range: always within [-2^(DW-1), 2^(DW-1)-1]. No saturation logic is required. Truncate to DW bits after the shift.
- Output buffer: 2 entries, circular, with a 2-bit count.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged. When full, the pop frees a slot and the push succeeds.
  - Push when full without a pop: the result is dropped, buffer contents are unchanged, and ovf is set.
- out_data is stable while out_valid && !out_ready.
- ovf:
  - Set wins over clr_ovf in the same cycle.
  - Cleared only by clr_ovf or rst.
- sync_clr:
  - Clears acc, phase, FSM, the EMIT register and the buffer next edge. It does not clear ovf.
  - Overrides any simultaneous in_valid; that sample is discarded.
- Reset mid-block discards the partial sum and all buffered results.

Optional Feature:
- Macro: IIR_DECIMATOR_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt[7:0], a saturating count of dropped results.
  - Saturates at 255.
  - Cleared by rst and clr_ovf, not by sync_clr.
  - Increments in the same cycle ovf is set.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package iir_dsp_pkg:
  - SAMPLE_W = 16.
  - typedef logic signed [SAMPLE_W-1:0] sample_t.
  - typedef enum logic [0:0] {DEC_IDLE, DEC_ACC} dec_state_e.
- Sub-module dec_out_fifo: the 2-entry buffer with push/pop/full/empty and a drop indication. It is the natural split. The rounding/accumulate logic stays in the top module.

Test Plan:
- DECIM=4, samples 100,101,102,103 back-to-back, out_ready=1 → single out_valid pulse with out_data=102, 2 cycles after the 4th sample.
- DECIM=4, samples -1,-2,-1,-2 → out_data=-1 (sum -6, round-half-up). Then samples 32767 ×4 → 32767, and -32768 ×4 → -32768.
- in_valid toggling 1,0,1,0… over 8 samples of value 10 → exactly 2 results of 10. Phase holds across gaps.
- out_ready=0, 16 continuous samples (4 blocks) →
  - Buffer holds blocks 1–2, blocks 3–4 dropped, ovf=1.
  - With the macro defined, drop_cnt=2.
  - Raise out_ready → exactly 2 pops in order, then out_valid=0.
- Buffer full and out_ready=1 in the same cycle as an EMIT push → no drop, count stays 2, ovf stays 0.
- Async rst pulse after 2 samples of a block, then 4 samples of 50 → first output is 50. sync_clr mid-block behaves the same, and ovf is preserved across it.
